// File: rtl/output_buffer_pkg.sv
// Shared types and default sizes for the output buffer slice.
// Optional feature macro: OUTPUT_BUFFER_OVERWRITE_DETECT_EN.
package output_buffer_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/output_buffer_if.sv
// Write, read, drain and stream signals of the output buffer.
// overwrite_err exists only with OUTPUT_BUFFER_OVERWRITE_DETECT_EN.
interface output_buffer_if
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              drain_start;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              drain_done;
  logic              busy;
  logic [ADDR_W:0]   count;
`ifdef OUTPUT_BUFFER_OVERWRITE_DETECT_EN
  logic              overwrite_err;
`endif

  modport master (
`ifdef OUTPUT_BUFFER_OVERWRITE_DETECT_EN
    input  overwrite_err,
`endif
    output wr_en, wr_addr, wr_data,
    output rd_req, rd_addr,
    output drain_start, out_ready,
    input  rd_valid, rd_data,
    input  out_valid, out_data, out_addr,
    input  drain_done, busy, count
  );

  modport slave (
`ifdef OUTPUT_BUFFER_OVERWRITE_DETECT_EN
    output overwrite_err,
`endif
    input  wr_en, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  drain_start, out_ready,
    output rd_valid, rd_data,
    output out_valid, out_data, out_addr,
    output drain_done, busy, count
  );

endinterface

// File: rtl/output_buffer_mem.sv
// Result storage plus per-entry valid bits.
// A write beats a clear to the same entry in the same cycle.
module output_buffer_mem
  import output_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word,
  output logic [DEPTH-1:0]  valid
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_addr] <= 1'b0;
      if (wr_en)  valid[wr_addr]  <= 1'b1;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/output_buffer.sv
// Output buffer: random reads, ordered drain stream, valid count.
// Build with OUTPUT_BUFFER_OVERWRITE_DETECT_EN for overwrite_err.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic          clk,
  input logic          rst,
  output_buffer_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W:0]   cnt;
  logic              rd_fire;
  logic              hs;
  logic              clr_en;
  logic              last;

  assign rd_fire  = (state == IDLE) && bus.rd_req;
  assign hs       = bus.out_valid && bus.out_ready;
  assign clr_en   = rd_fire || hs;
  assign clr_addr = rd_fire ? bus.rd_addr : bus.out_addr;
  assign raddr    = (state == IDLE) ? bus.rd_addr : ptr;
  assign last     = (ptr == ADDR_W'(DEPTH - 1));
  assign bus.busy = (state != IDLE);

  output_buffer_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .rd_addr  (raddr),
    .rd_word  (rd_word),
    .valid    (valid)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + (ADDR_W + 1)'(valid[i]);
    end
  end

  assign bus.count = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_addr   <= '0;
      bus.drain_done <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      if (rd_fire) begin
        bus.rd_data <= valid[raddr] ? rd_word : '0;
      end
      unique case (state)
        IDLE: begin
          if (bus.drain_start) begin
            state <= DRAIN;
            ptr   <= '0;
          end
        end
        DRAIN: begin
          if (bus.out_valid) begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              if (last) state <= DONE;
              else      ptr   <= ptr + 1'b1;
            end
          end else if (valid[ptr]) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rd_word;
            bus.out_addr  <= ptr;
          end else if (last) begin
            state <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle raises the pulse, second returns to IDLE.
          if (!bus.drain_done) begin
            bus.drain_done <= 1'b1;
          end else begin
            bus.drain_done <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_BUFFER_OVERWRITE_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overwrite_err <= 1'b0;
    end else if (bus.wr_en && valid[bus.wr_addr]) begin
      bus.overwrite_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit result entries; power of two.
REQ-002 Parameter DATA_W, default 32, entry width.
REQ-003 Parameter ADDR_W, default 4, equals log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_en  in  1  write strobe from the accumulator's output_buffer_enable.
REQ-007 wr_addr  in  ADDR_W  write address from the accumulator's output_buffer_addr.
REQ-008 wr_data  in  DATA_W  write data from the accumulator's output_data.
REQ-009 rd_req  in  1  random-access read request.
REQ-010 rd_addr  in  ADDR_W  read address.
REQ-011 rd_valid  out  1  one-cycle pulse; rd_data is valid.
REQ-012 rd_data  out  DATA_W  read result.
REQ-013 drain_start  in  1  pulse; start streaming all valid entries.
REQ-014 out_valid  out  1  stream data valid.
REQ-015 out_ready  in  1  stream sink ready.
REQ-016 out_data  out  DATA_W  stream data.
REQ-017 out_addr  out  ADDR_W  address of the streamed entry.
REQ-018 drain_done  out  1  one-cycle pulse at the end of a drain.
REQ-019 busy  out  1  high while the FSM is not IDLE.
REQ-020 count  out  ADDR_W+1  number of valid entries.
REQ-021 overwrite_err  out  1  sticky flag; present only under the macro in REQ-036.

Function
REQ-022 Write: when wr_en=1 at posedge, mem[wr_addr] SHALL be loaded with wr_data and valid[wr_addr] SHALL be set; writes are accepted in every FSM state.
REQ-023 Read: rd_req=1 in IDLE SHALL produce rd_valid=1 and rd_data=mem[rd_addr] exactly one cycle later, and valid[rd_addr] SHALL be cleared (consume-on-read).
REQ-024 A read of an invalid entry SHALL return rd_data=0 with rd_valid=1.
REQ-025 rd_req outside IDLE SHALL be ignored; rd_valid SHALL stay 0.
REQ-026 A write and a read to the same address in the same cycle SHALL return the old data, and valid SHALL remain set.
REQ-027 The FSM SHALL have three states: IDLE, DRAIN, and DONE; drain_start in IDLE moves it to DRAIN, and drain_start in any other state is ignored.
REQ-028 In DRAIN, a scan pointer starting at 0 SHALL present each valid entry in ascending address order on out_data/out_addr with out_valid=1, and SHALL skip invalid entries at a rate of one per cycle.
REQ-029 out_data, out_addr, and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 On an out_valid&&out_ready handshake, the presented entry's valid bit SHALL clear, unless a write to the same address occurs in the same cycle; in that case the bit stays set and the streamed data is the old value.
REQ-031 After address DEPTH-1 is handled, the FSM SHALL go to DONE, assert drain_done for one cycle, and then return to IDLE; the pointer does not wrap.
REQ-032 A drain with count=0 SHALL scan without asserting out_valid and then finish via DONE.
REQ-033 count SHALL track sets and clears each cycle; a simultaneous set and clear of different entries leaves count unchanged, and count never exceeds DEPTH.

Reset
REQ-034 While rst=1, the buffer SHALL reset: FSM=IDLE, pointer=0, all valid bits=0, count=0, and rd_valid, rd_data, out_valid, out_data, out_addr, drain_done, and overwrite_err all 0. mem contents are don't-care.
REQ-035 A reset mid-drain SHALL abort the drain without asserting drain_done.

Configuration
REQ-036 With macro OUTPUT_BUFFER_OVERWRITE_DETECT_EN defined, a write to an entry whose valid bit is already set SHALL set overwrite_err, which stays set until reset; the write still completes.
REQ-037 Without the macro, the overwrite_err port and its logic SHALL be absent.

Structure
REQ-038 The shared package SHALL hold the FSM state enum (IDLE/DRAIN/DONE) and the defaults for DEPTH, DATA_W, and ADDR_W.
REQ-039 The storage array and valid bits SHALL form one sub-module, output_buffer_mem; the FSM, handshake, and count logic stay in the top level.

Verification
REQ-040 Write 0xDEADBEEF to address 3, then read address 3: rd_valid one cycle later with 0xDEADBEEF, count goes 1→0, and a re-read returns 0.
REQ-041 Write addresses 1, 5, and 9 with 0x11, 0x55, and 0x99, then drain with out_ready=1: the stream is (1,0x11), (5,0x55), (9,0x99), drain_done pulses, and count=0.
REQ-042 Drain with out_ready held low for 3 cycles on the first entry: out_data stays stable and is transferred exactly once.
REQ-043 Drain an empty buffer: out_valid never rises, drain_done pulses DEPTH+1 to DEPTH+2 cycles after drain_start, and busy falls afterward.
REQ-044 Write address 2 twice without a read, macro defined: overwrite_err=1 and a read returns the second value; macro undefined: the port is absent.
REQ-045 Assert rst during a drain after 2 handshakes: all outputs are 0 immediately, no drain_done is asserted, and count=0.
